// File: rtl/cdecn_dp.sv
`default_nettype none
// ============================================================================
// Module   : cdecn_dp
// Purpose  : CDEC data path with a single XBUS and an external ALU. It adds a
//            req/ack memory handshake with stall and a registered debug read
//            port. Optional memory watchdog: define MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cdecn_dp #(
    parameter int              DW        = 8,
    parameter int              AW        = 8,
    parameter int              NGR       = 3,
    parameter logic [DW-1:0]   RST_PC    = '0,
    parameter int              TO_CYCLES = 255
) (
    input  logic          clock,
    input  logic          reset_N,
    input  logic [11:0]   ctrl,
    output logic [DW-1:0] I,
    output logic [2:0]    SZCy,
    output logic          stall,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_t,
    output logic          alu_cy,
    input  logic [DW-1:0] alu_res,
    input  logic [2:0]    alu_szcy,
    output logic [AW-1:0] mem_adrs,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    input  logic          mem_ack,
    output logic          mem_err,
    input  logic [7:0]    resad,
    output logic [DW-1:0] resdt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] pc_q, i_q, t_q, r_q, wdr_q, rdr_q, flg_q, resdt_q;
    logic [AW-1:0] mar_q;
    logic [DW-1:0] g_q [NGR];
    logic          req_q, we_q;

    logic [1:0]    w_mmrw;
    logic          w_fwr, w_rwr;
    logic [3:0]    w_xdst, w_xsrc;
    logic          w_rd, w_wr;
    logic [DW-1:0] w_xbus, w_resdt;
    logic          w_idle, w_launch, w_done, w_rd_load, w_to_hit, w_timeout;

    assign w_mmrw = ctrl[11:10];
    assign w_fwr  = ctrl[9];
    assign w_rwr  = ctrl[8];
    assign w_xdst = ctrl[7:4];
    assign w_xsrc = ctrl[3:0];
    assign w_rd   = (w_mmrw == 2'b10);
    assign w_wr   = (w_mmrw == 2'b01);

    always_comb begin
        w_xbus = '1;
        case (w_xsrc)
            4'd0:    w_xbus = pc_q;
            4'd1:    w_xbus = r_q;
            4'd2:    w_xbus = rdr_q;
            4'd3:    w_xbus = flg_q;
            default: ;
        endcase
        for (int k = 0; k < NGR; k++) begin
            if (w_xsrc == 4'(8 + k)) w_xbus = g_q[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        w_idle    = (state_q == S_IDLE);
        w_launch  = 1'b0;
        w_done    = 1'b0;
        w_rd_load = 1'b0;
        w_to_hit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_rd || w_wr) begin
                    state_d  = S_BUSY;
                    w_launch = 1'b1;
                end
            end
            S_BUSY: begin
                // An ack in the watchdog's final cycle still completes normally.
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    w_done    = 1'b1;
                    w_rd_load = ~we_q;
                end else if (w_timeout) begin
                    state_d  = S_IDLE;
                    w_done   = 1'b1;
                    w_to_hit = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int c_TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [c_TO_W-1:0] to_cnt_q;
    logic              err_q;

    assign w_timeout = (to_cnt_q == c_TO_W'(TO_CYCLES - 1));
    assign mem_err   = err_q;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (w_launch) begin
                to_cnt_q <= '0;
            end else if (state_q == S_BUSY) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (w_to_hit) err_q <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            i_q     <= '0;
            t_q     <= '0;
            r_q     <= '0;
            mar_q   <= '0;
            wdr_q   <= '0;
            rdr_q   <= '0;
            flg_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            resdt_q <= '0;
            for (int k = 0; k < NGR; k++) g_q[k] <= '0;
        end else begin
            state_q <= state_d;
            resdt_q <= w_resdt;
            if (w_launch) begin
                req_q <= 1'b1;
                we_q  <= w_wr;
            end else if (w_done) begin
                req_q <= 1'b0;
                we_q  <= 1'b0;
            end
            if (w_rd_load) rdr_q <= mem_rdata;
            if (w_idle) begin
                case (w_xdst)
                    4'd0:    pc_q  <= w_xbus;
                    4'd1:    i_q   <= w_xbus;
                    4'd2:    t_q   <= w_xbus;
                    4'd3:    mar_q <= w_xbus[AW-1:0];
                    4'd4:    wdr_q <= w_xbus;
                    default: ;
                endcase
                for (int k = 0; k < NGR; k++) begin
                    if (w_xdst == 4'(8 + k)) g_q[k] <= w_xbus;
                end
                if (w_rwr) r_q <= alu_res;
                if (w_fwr) flg_q <= {{(DW-4){1'b0}}, alu_szcy, 1'b0};
            end
        end
    end

    always_comb begin
        w_resdt = '0;
        case (resad)
            8'h00:   w_resdt = pc_q;
            8'h01:   w_resdt = i_q;
            8'h02:   w_resdt = t_q;
            8'h03:   w_resdt = r_q;
            8'h04:   w_resdt[AW-1:0] = mar_q;
            8'h05:   w_resdt = mem_rdata;
            8'h06:   w_resdt = rdr_q;
            8'h07:   w_resdt = wdr_q;
            8'h10:   w_resdt = flg_q;
            8'h11:   w_resdt[3:0] = {mem_err, we_q, req_q, stall};
            default: ;
        endcase
        for (int k = 0; k < NGR; k++) begin
            if (resad == 8'(8 + k)) w_resdt = g_q[k];
        end
    end

    assign I         = i_q;
    assign SZCy      = flg_q[3:1];
    assign stall     = (state_q == S_BUSY);
    assign alu_x     = w_xbus;
    assign alu_t     = t_q;
    assign alu_cy    = flg_q[1];
    assign mem_adrs  = mar_q;
    assign mem_wdata = wdr_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign resdt     = resdt_q;

endmodule
`default_nettype wire

// File: doc/cdecn_dp.md
Name: cdecn_dp

Overview:
- Parametrised next-generation CDEC data path: DW-bit data, AW-bit address, NGR general registers.
- Single internal XBUS; ALU is external, connected through the alu_* ports.
- Adds a req/ack memory handshake with stall, plus a registered debug-monitor read port.
- Sits between the CDEC sequencer (drives ctrl, aluop) and the memory/bus interface.

Parameters:
DW, 8, data/register width (>=4)
AW, 8, memory address width (MAR width), AW<=DW; MAR loads XBUS[AW-1:0]
NGR, 3, number of general registers G0..G(NGR-1), 1..8
RST_PC, 0, PC reset value (DW bits)
TO_CYCLES, 255, memory watchdog limit, used only with MEM_TIMEOUT_EN

Ports:
clock  in  1  system clock, rising edge
reset_N  in  1  asynchronous active-low reset
ctrl  in  12  {mmrw[1:0], fwr, rwr, xdst[3:0], xsrc[3:0]}
I  out  DW  instruction register
SZCy  out  3  FLG[3:1]
stall  out  1  memory access in progress; sequencer must hold
alu_x  out  DW  XBUS to ALU
alu_t  out  DW  T register to ALU
alu_cy  out  1  FLG[1]
alu_res  in  DW  ALU result
alu_szcy  in  3  ALU flags {S,Z,Cy}
mem_adrs  out  AW  = MAR
mem_wdata  out  DW  = WDR
mem_rdata  in  DW  read data
mem_req  out  1  request, registered
mem_we  out  1  1=write, valid with mem_req
mem_ack  in  1  completion
mem_err  out  1  sticky timeout error (0 without MEM_TIMEOUT_EN)
resad  in  8  debug resource address
resdt  out  DW  debug resource data, registered

Behaviour:
- Reset (async, reset_N=0):
  - PC=RST_PC.
  - I, T, R, MAR, WDR, RDR, FLG, all Gk = 0.
  - FSM=IDLE; mem_req=0, mem_we=0, stall=0, mem_err=0, resdt=0.
- XBUS source (xsrc):
  - 0 PC, 1 R, 2 RDR, 3 FLG, 8+k Gk (k<NGR).
  - All other codes = all-ones.
- Destination (xdst), written on the clock edge, only when FSM=IDLE:
  - 0 PC, 1 I, 2 T, 3 MAR, 4 WDR, 8+k Gk (k<NGR).
  - Other codes write nothing.
- Result/flag writes: rwr=1 -> R<=alu_res; fwr=1 -> FLG<={0..., alu_szcy, 1'b0}. Both IDLE-only.
- mmrw: 10 = read, 01 = write, 00/11 = none.
- FSM IDLE:
  - On mmrw read/write, the cycle's register writes complete.
  - Next state BUSY; mem_req=1 and mem_we=(write) from the next cycle.
  - Address is MAR after this cycle's write, so MAR load and launch may share a cycle.
- FSM BUSY:
  - stall=1; mem_req held; ctrl ignored entirely (no register writes, no new launch).
  - mem_ack=1 sampled: for a read, RDR<=mem_rdata on that edge.
  - On ack: mem_req=0, FSM->IDLE, stall=0 from the next cycle.
- Latency: minimum access is 2 cycles (launch + ack in the first BUSY cycle).
- mem_ack in IDLE is ignored.
- Reset mid-access aborts: mem_req drops asynchronously and RDR is unchanged.
- resdt updates every clock, 1-cycle latency, from resad:
  - 00 PC, 01 I, 02 T, 03 R, 04 MAR (zero-extended), 05 mem_rdata, 06 RDR, 07 WDR.
  - 08+k Gk (0 if k>=NGR).
  - 10 FLG.
  - 11 {0..., mem_err, mem_we, mem_req, stall}.
  - Others 0.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - A counter clears on launch and increments each BUSY cycle.
  - If it reaches TO_CYCLES without ack: FSM->IDLE, mem_req=0, RDR unchanged, mem_err set (sticky until reset).
  - An ack arriving in the timeout cycle wins.
- Undefined: no counter; BUSY waits indefinitely; mem_err tied 0.

Test Plan:
- Reset with RST_PC=8'h40 -> PC=40, all other registers 0, mem_req=0; resad=00 gives resdt=40 one cycle later.
- xsrc=8 (G0=8'h5A), xdst=10 (G2) -> G2=5A; xsrc=5 (undefined) into T -> T=FF.
- MAR<=8'h12 with mmrw=10 in the same cycle; ack after 3 BUSY cycles with rdata=8'hC3 -> mem_adrs=12, stall=1 for 3 cycles, RDR=C3, no register writes during BUSY.
- WDR=8'h77, mmrw=01, ack on the first BUSY cycle -> mem_we=1, mem_wdata=77, mem_req high exactly 1 cycle, RDR unchanged.
- rwr=1, fwr=1 with alu_res=00, alu_szcy=3'b011 -> R=00, FLG=8'h06, SZCy=011, alu_cy=1.
- MEM_TIMEOUT_EN, TO_CYCLES=4, no ack -> FSM returns to IDLE after 4 BUSY cycles, mem_err=1; resad=11 shows bit 3 set. Separately, assert reset_N mid-BUSY -> mem_req=0 immediately.
